// File: rtl/dmem_port_if.sv
// Data-memory port: shared op codes and widths,
// plus the req/ack bus between responder and memory.
package dmem_pkg;
  localparam int ADDR_W   = 32;
  localparam int WORD_W   = 32;
  localparam int MEM_OP_W = 4;

  localparam logic [MEM_OP_W-1:0] MEM_OP_NONE     = 4'd0;
  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_BYTE  = 4'd1;
  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_HALF  = 4'd2;
  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_WORD  = 4'd3;
  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_UBYTE = 4'd4;
  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_UHALF = 4'd5;
  localparam logic [MEM_OP_W-1:0] MEM_OP_WR_BYTE  = 4'd6;
  localparam logic [MEM_OP_W-1:0] MEM_OP_WR_HALF  = 4'd7;
  localparam logic [MEM_OP_W-1:0] MEM_OP_WR_WORD  = 4'd8;
endpackage

interface dmem_port_if;
  import dmem_pkg::*;

  logic                o_bus_req;
  logic                o_bus_we;
  logic [ADDR_W-1:0]   o_bus_addr;
  logic [WORD_W/8-1:0] o_bus_be;
  logic [WORD_W-1:0]   o_bus_wdata;
  logic [WORD_W-1:0]   i_bus_rdata;
  logic                i_bus_ack;

  modport master (
    output o_bus_req, o_bus_we, o_bus_addr,
    output o_bus_be, o_bus_wdata,
    input  i_bus_rdata, i_bus_ack
  );

  modport slave (
    input  o_bus_req, o_bus_we, o_bus_addr,
    input  o_bus_be, o_bus_wdata,
    output i_bus_rdata, i_bus_ack
  );
endinterface

// File: rtl/dmem_port.sv
// Memory-stage data port: issues one req/ack bus
// transaction per access and returns aligned load data.
module dmem_port
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic [MEM_OP_W-1:0] i_mem_op,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [WORD_W-1:0]   i_wdata,
  output logic                o_stall,
  output logic [WORD_W-1:0]   o_rdata,
  output logic                o_misalign,
  output logic                o_bus_err,
  dmem_port_if.master         bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]    cnt;
  logic [MEM_OP_W-1:0] op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          be_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [1:0]          lane_q;
  logic                we_q;

  logic is_rd, is_wr, sz_b, sz_h, sz_w;
  logic valid, mis, issue, ack_ok, tmo, tmo_hit;
  logic [3:0]        be_c;
  logic [WORD_W-1:0] wdata_c;
  logic [WORD_W-1:0] rdata_x;
  logic [7:0]        byte_x;
  logic [15:0]       half_x;

  // classify the incoming op by direction and size
  always_comb begin
    is_rd = 1'b0;
    is_wr = 1'b0;
    sz_b  = 1'b0;
    sz_h  = 1'b0;
    sz_w  = 1'b0;
    unique case (i_mem_op)
      MEM_OP_RD_BYTE,
      MEM_OP_RD_UBYTE: begin is_rd = 1'b1; sz_b = 1'b1; end
      MEM_OP_RD_HALF,
      MEM_OP_RD_UHALF: begin is_rd = 1'b1; sz_h = 1'b1; end
      MEM_OP_RD_WORD:  begin is_rd = 1'b1; sz_w = 1'b1; end
      MEM_OP_WR_BYTE:  begin is_wr = 1'b1; sz_b = 1'b1; end
      MEM_OP_WR_HALF:  begin is_wr = 1'b1; sz_h = 1'b1; end
      MEM_OP_WR_WORD:  begin is_wr = 1'b1; sz_w = 1'b1; end
      default: ;
    endcase
  end

  assign valid = is_rd | is_wr;
  assign mis   = (sz_h & i_addr[0])
               | (sz_w & (|i_addr[1:0]));

  // byte enables and lane-replicated store data
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = i_wdata;
    unique case (1'b1)
      sz_b: begin
        be_c    = 4'b0001 << i_addr[1:0];
        wdata_c = {4{i_wdata[7:0]}};
      end
      sz_h: begin
        be_c    = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign tmo_hit = (TIMEOUT != 0)
                && (cnt == CNT_W'(TIMEOUT - 1));

  // next state; ack wins over a same-cycle timeout
  always_comb begin
    state_n = state;
    issue   = 1'b0;
    ack_ok  = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (valid && !mis) begin
          issue   = 1'b1;
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.i_bus_ack) begin
          ack_ok  = 1'b1;
          state_n = S_DONE;
        end else if (tmo_hit) begin
          tmo     = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign o_stall    = issue | (state == S_REQ);
  assign o_misalign = (state == S_IDLE) & valid & mis;

  assign bus.o_bus_req   = (state == S_REQ);
  assign bus.o_bus_we    = we_q;
  assign bus.o_bus_addr  = addr_q;
  assign bus.o_bus_be    = be_q;
  assign bus.o_bus_wdata = wdata_q;

  // pick the addressed lane and extend it
  always_comb begin
    byte_x  = bus.i_bus_rdata[8*lane_q +: 8];
    half_x  = bus.i_bus_rdata[16*lane_q[1] +: 16];
    rdata_x = '0;
    unique case (op_q)
      MEM_OP_RD_BYTE:  rdata_x = {{24{byte_x[7]}}, byte_x};
      MEM_OP_RD_UBYTE: rdata_x = {24'b0, byte_x};
      MEM_OP_RD_HALF:  rdata_x = {{16{half_x[15]}}, half_x};
      MEM_OP_RD_UHALF: rdata_x = {16'b0, half_x};
      MEM_OP_RD_WORD:  rdata_x = bus.i_bus_rdata;
      default:         rdata_x = '0;
    endcase
  end

  // state register and ack-timeout counter
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (issue)
        cnt <= '0;
      else if (state == S_REQ && !bus.i_bus_ack)
        cnt <= cnt + 1'b1;
    end
  end

  // latch the access so bus outputs stay stable
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      op_q    <= MEM_OP_NONE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      lane_q  <= '0;
      we_q    <= 1'b0;
    end else if (issue) begin
      op_q    <= i_mem_op;
      addr_q  <= {i_addr[ADDR_W-1:2], 2'b00};
      be_q    <= be_c;
      wdata_q <= wdata_c;
      lane_q  <= i_addr[1:0];
      we_q    <= is_wr;
    end
  end

  // load result and error pulse
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      o_rdata   <= '0;
      o_bus_err <= 1'b0;
    end else begin
      o_bus_err <= tmo;
      if (ack_ok)
        o_rdata <= rdata_x;
      else if (tmo || o_misalign)
        o_rdata <= '0;
    end
  end

endmodule

// File: doc/dmem_port.md
Name: dmem_port

Overview:
- Data-memory responder for the memory stage. Accepts the pipeline's memory operation, address and store data, and runs a req/ack transaction on the data-memory bus.
- Stalls the pipeline while a transaction is outstanding.
- Returns read data already lane-aligned and sign- or zero-extended per operation, so the memory stage can mux it straight to writeback.

Parameters:
- TIMEOUT, 16, bus cycles to wait for i_bus_ack before aborting; 0 disables the timeout.
- CNT_W, 5, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- clr_n  in  1  asynchronous active-low reset
- i_mem_op  in  `MEM_OP_W  operation code from mem_codes.vh; `MEM_OP_NONE means no access
- i_addr  in  `ADDR_W  byte address
- i_wdata  in  `WORD_W  store data, right-justified
- o_stall  out  1  hold the pipeline
- o_rdata  out  `WORD_W  aligned, extended load result
- o_misalign  out  1  misaligned access rejected (combinational)
- o_bus_err  out  1  one-cycle pulse when a transaction times out
- o_bus_req  out  1  bus request, held until ack
- o_bus_we  out  1  1 = write
- o_bus_addr  out  `ADDR_W  word-aligned address (low 2 bits forced to 0)
- o_bus_be  out  `WORD_W/8  byte enables
- o_bus_wdata  out  `WORD_W  lane-replicated store data
- i_bus_rdata  in  `WORD_W  full read word
- i_bus_ack  in  1  transaction complete, valid for one cycle

Behaviour:
- Reset (async, clr_n=0):
  - State goes to IDLE; counter cleared; all registered outputs are 0.
  - o_bus_req drops immediately, even mid-transaction. The in-flight operation is discarded and any later ack is ignored.
- Operation classes:
  - Read: RD_BYTE, RD_HALF, RD_WORD, RD_UBYTE, RD_UHALF.
  - Write: WR_BYTE, WR_HALF, WR_WORD.
  - Any other code is treated as NONE.
- Alignment:
  - Half is misaligned if addr[0]=1.
  - Word is misaligned if addr[1:0]≠0.
  - Misaligned op in IDLE: o_misalign=1 in the same cycle, no stall, no bus access, o_rdata=0, state stays IDLE.
- FSM:
  - IDLE: on a valid aligned op, latch op, addr, be, wdata and lane select. Assert o_stall combinationally in this cycle and go to REQ.
  - REQ: o_bus_req=1, o_stall=1, bus outputs held stable from the latched values.
    - On i_bus_ack: capture the extracted/extended read data into o_rdata and go to DONE.
    - If the counter reaches TIMEOUT first: drop req, pulse o_bus_err, o_rdata=0, go to DONE.
  - DONE: o_stall=0 and o_rdata valid; the pipeline advances at the end of this cycle.
    - i_mem_op is ignored here (it is still the old op), so there is never a double issue.
    - Next state is IDLE.
- Latency: minimum 3 cycles per access (IDLE→REQ→DONE) with ack in the first REQ cycle. Back-to-back ops issue from the IDLE cycle after DONE.
- Write lanes, with l = addr[1:0]:
  - Byte: be = 1<<l; wdata = {4{wdata[7:0]}}.
  - Half: be = 0011 if addr[1]=0, else 1100; wdata = {2{wdata[15:0]}}.
  - Word: be = 1111.
- Read lanes: be is the same pattern as for writes.
  - Byte: i_bus_rdata[8l+7:8l].
  - Half: i_bus_rdata[16·addr[1]+15 : 16·addr[1]].
  - RD_BYTE and RD_HALF sign-extend; RD_UBYTE and RD_UHALF zero-extend; RD_WORD passes the word through.
- Writes: o_rdata=0 in DONE.
- o_rdata holds its value until the next DONE, a misaligned op, or reset.
- Ack outside REQ is ignored.
- Timeout counter:
  - Clears on entry to REQ and increments each REQ cycle without ack.
  - Ack in the same cycle the counter hits TIMEOUT counts as success.

Test Plan:
- RD_BYTE addr 0x103, bus word 0x80AB_CDEF, ack on first REQ cycle -> o_bus_addr 0x100, be 1000, o_stall high for 2 cycles, DONE o_rdata 0xFFFF_FF80. Repeat with RD_UBYTE -> 0x0000_0080.
- WR_HALF addr 0x42, wdata 0x1234_BEEF -> be 1100, o_bus_wdata 0xBEEF_BEEF, we=1, o_rdata=0 in DONE.
- RD_WORD addr 0x06 -> o_misalign=1 same cycle, o_stall=0, o_bus_req never rises.
- Ack withheld, TIMEOUT=16 -> req held 16 cycles, then o_bus_err pulses for 1 cycle, DONE with o_rdata=0, state back to IDLE.
- Back-to-back WR_WORD then RD_WORD at the same address, ack delayed 3 cycles each -> exactly two req pulses, no reissue in DONE, read returns the written word.
- clr_n low during REQ, late ack arrives after release -> req drops asynchronously, late ack ignored, all outputs 0, next op issues normally.
